// File: rtl/param_updown_counter_pkg.sv
// Shared types for the parametrised up/down counter: boundary modes and FSM states.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10
  } mode_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/param_updown_counter_if.sv
// Control and status bundle of the counter. The counter has no valid/ready
// handshake: every input is sampled on each rising clock edge.
interface param_updown_counter_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              en_ctrl_in;
  logic              set_ctrl_in;
  logic              up_ctrl_in;
  logic [WIDTH-1:0]  counter_in;
  logic [STEP_W-1:0] step_in;
  logic [WIDTH-1:0]  limit_in;
  logic [1:0]        mode_in;
  logic              flag_clr_in;
  logic [WIDTH-1:0]  counter_out;
  logic              ovf_out;
  logic              unf_out;
  logic              ovf_sticky_out;
  logic              unf_sticky_out;
  logic              tc_out;
  logic              halt_out;

  modport master (
    output en_ctrl_in, set_ctrl_in, up_ctrl_in, counter_in, step_in,
           limit_in, mode_in, flag_clr_in,
    input  counter_out, ovf_out, unf_out, ovf_sticky_out, unf_sticky_out,
           tc_out, halt_out
  );

  modport slave (
    input  en_ctrl_in, set_ctrl_in, up_ctrl_in, counter_in, step_in,
           limit_in, mode_in, flag_clr_in,
    output counter_out, ovf_out, unf_out, ovf_sticky_out, unf_sticky_out,
           tc_out, halt_out
  );
endinterface

// File: rtl/param_updown_counter_step.sv
// Combinational next-value unit: applies one up/down step against [0, limit]
// and resolves overflow/underflow according to the boundary mode.
module counter_step_unit
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  cnt,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              up,
  input  logic [1:0]        mode,
  output logic [WIDTH-1:0]  nxt,
  output logic              ovf,
  output logic              unf
);
  // One extra bit beyond the wider operand so the sum never wraps silently.
  localparam int EW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;

  logic [EW-1:0] cnt_x;
  logic [EW-1:0] step_x;
  logic [EW-1:0] lim_x;
  logic [EW-1:0] sum_x;
  logic [EW-1:0] dif_x;

  assign cnt_x  = EW'(cnt);
  assign step_x = EW'(step);
  assign lim_x  = EW'(limit);
  assign sum_x  = cnt_x + step_x;
  assign dif_x  = cnt_x - step_x;

  always_comb begin
    nxt = cnt;
    ovf = 1'b0;
    unf = 1'b0;
    if (step_x == '0) begin
      nxt = cnt;
    end else if (up) begin
      if (sum_x > lim_x) begin
        ovf = 1'b1;
        case (mode_t'(mode))
          MODE_SAT, MODE_ONESHOT: nxt = limit;
          default:                nxt = '0;
        endcase
      end else begin
        nxt = WIDTH'(sum_x);
      end
    end else begin
      if (cnt_x < step_x) begin
        unf = 1'b1;
        case (mode_t'(mode))
          MODE_SAT, MODE_ONESHOT: nxt = '0;
          default:                nxt = limit;
        endcase
      end else begin
        nxt = WIDTH'(dif_x);
      end
    end
  end
endmodule

// File: rtl/param_updown_counter.sv
// Loadable up/down counter with wrap/saturate/one-shot boundaries, event pulses,
// sticky flags and a RUN/HALT FSM. Only tc_out is combinational.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STEP_W  = 4,
  parameter int RST_VAL = 0
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  param_updown_counter_if.slave  bus,
  output state_t                 state_dbg
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             ovf_st_q, ovf_st_d, unf_st_q, unf_st_d;
  logic [WIDTH-1:0] step_nxt;
  logic             step_ovf, step_unf;
  logic [WIDTH-1:0] load_val;

  counter_step_unit #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_step (
    .cnt   (cnt_q),
    .step  (bus.step_in),
    .limit (bus.limit_in),
    .up    (bus.up_ctrl_in),
    .mode  (bus.mode_in),
    .nxt   (step_nxt),
    .ovf   (step_ovf),
    .unf   (step_unf)
  );

  assign load_val = (bus.counter_in > bus.limit_in) ? bus.limit_in : bus.counter_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (bus.set_ctrl_in) begin
      cnt_d   = load_val;
      state_d = ST_RUN;
    end else if (bus.en_ctrl_in && state_q == ST_RUN) begin
      cnt_d = step_nxt;
      ovf_d = step_ovf;
      unf_d = step_unf;
      if ((step_ovf || step_unf) && mode_t'(bus.mode_in) == MODE_ONESHOT)
        state_d = ST_HALT;
    end
    // A new event on the same edge as a clear keeps the flag set.
    ovf_st_d = (ovf_st_q && !bus.flag_clr_in) || ovf_d;
    unf_st_d = (unf_st_q && !bus.flag_clr_in) || unf_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_RUN;
      cnt_q    <= WIDTH'(RST_VAL);
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      ovf_st_q <= 1'b0;
      unf_st_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      ovf_st_q <= ovf_st_d;
      unf_st_q <= unf_st_d;
    end
  end

  assign bus.counter_out    = cnt_q;
  assign bus.ovf_out        = ovf_q;
  assign bus.unf_out        = unf_q;
  assign bus.ovf_sticky_out = ovf_st_q;
  assign bus.unf_sticky_out = unf_st_q;
  assign bus.halt_out       = (state_q == ST_HALT);
  assign bus.tc_out         = (cnt_q == bus.limit_in);
  assign state_dbg          = state_q;
endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter (WIDTH=8, STEP_W=4, RST_VAL=0).
module tb_param_updown_counter;
  import counter_pkg::*;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  state_t state_dbg;
  int     pass_cnt  = 0;
  int     total_cnt = 0;

  param_updown_counter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  param_updown_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W), .RST_VAL(0)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Inputs are changed 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en_ctrl_in  = 1'b0;
    bus.set_ctrl_in = 1'b0;
    bus.up_ctrl_in  = 1'b1;
    bus.counter_in  = '0;
    bus.step_in     = '0;
    bus.mode_in     = 2'b00;
    bus.flag_clr_in = 1'b0;
  endtask

  task automatic load(input logic [7:0] val, input logic [7:0] lim);
    idle_inputs();
    bus.limit_in    = lim;
    bus.counter_in  = val;
    bus.set_ctrl_in = 1'b1;
    tick();
    bus.set_ctrl_in = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.limit_in    = 8'hFF;
    bus.set_ctrl_in = 1'b1;
    bus.counter_in  = 8'h33;
    bus.en_ctrl_in  = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle_inputs();
    total_cnt++;
    if (bus.counter_out !== 8'h00) $display("FAIL reset_cnt got %0h exp 0", bus.counter_out);
    else pass_cnt++;
    total_cnt++;
    if ({bus.ovf_out, bus.unf_out, bus.ovf_sticky_out, bus.unf_sticky_out, bus.halt_out} !== 5'b0)
      $display("FAIL reset_flags got %b exp 00000",
               {bus.ovf_out, bus.unf_out, bus.ovf_sticky_out, bus.unf_sticky_out, bus.halt_out});
    else pass_cnt++;
    total_cnt++;
    if (state_dbg !== ST_RUN) $display("FAIL reset_state got %0d exp 0", state_dbg);
    else pass_cnt++;
  endtask

  task automatic test_load();
    load(8'hF0, 8'h80);
    total_cnt++;
    if (bus.counter_out !== 8'h80) $display("FAIL load_clamp got %0h exp 80", bus.counter_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.ovf_out !== 1'b0 || bus.unf_out !== 1'b0)
      $display("FAIL load_pulse got %b%b exp 00", bus.ovf_out, bus.unf_out);
    else pass_cnt++;
    load(8'h42, 8'h80);
    total_cnt++;
    if (bus.counter_out !== 8'h42) $display("FAIL load_plain got %0h exp 42", bus.counter_out);
    else pass_cnt++;
  endtask

  task automatic test_wrap_up();
    load(8'd9, 8'h0A);
    bus.en_ctrl_in = 1'b1; bus.up_ctrl_in = 1'b1; bus.step_in = 4'd3; bus.mode_in = 2'b00;
    tick();
    total_cnt++;
    if (bus.counter_out !== 8'd0 || bus.ovf_out !== 1'b1 || bus.ovf_sticky_out !== 1'b1)
      $display("FAIL wrap_up_evt got cnt=%0h ovf=%b st=%b exp cnt=0 ovf=1 st=1",
               bus.counter_out, bus.ovf_out, bus.ovf_sticky_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.counter_out !== 8'd3 || bus.ovf_out !== 1'b0)
      $display("FAIL wrap_up_next got cnt=%0h ovf=%b exp cnt=3 ovf=0", bus.counter_out, bus.ovf_out);
    else pass_cnt++;
  endtask

  task automatic test_wrap_down();
    load(8'd1, 8'h0A);
    bus.en_ctrl_in = 1'b1; bus.up_ctrl_in = 1'b0; bus.step_in = 4'd3; bus.mode_in = 2'b11;
    tick();
    total_cnt++;
    if (bus.counter_out !== 8'h0A || bus.unf_out !== 1'b1)
      $display("FAIL wrap_down got cnt=%0h unf=%b exp cnt=a unf=1", bus.counter_out, bus.unf_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.counter_out !== 8'd7 || bus.unf_out !== 1'b0)
      $display("FAIL wrap_down_next got cnt=%0h unf=%b exp cnt=7 unf=0", bus.counter_out, bus.unf_out);
    else pass_cnt++;
  endtask

  task automatic test_sat_down();
    load(8'd2, 8'hFF);
    bus.en_ctrl_in = 1'b1; bus.up_ctrl_in = 1'b0; bus.step_in = 4'd4; bus.mode_in = 2'b01;
    tick();
    total_cnt++;
    if (bus.counter_out !== 8'd0 || bus.unf_out !== 1'b1 || bus.unf_sticky_out !== 1'b1)
      $display("FAIL sat_down got cnt=%0h unf=%b st=%b exp cnt=0 unf=1 st=1",
               bus.counter_out, bus.unf_out, bus.unf_sticky_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.counter_out !== 8'd0 || bus.unf_out !== 1'b1)
      $display("FAIL sat_down_repulse got cnt=%0h unf=%b exp cnt=0 unf=1", bus.counter_out, bus.unf_out);
    else pass_cnt++;
    load(8'hFE, 8'hFF);
    bus.en_ctrl_in = 1'b1; bus.up_ctrl_in = 1'b1; bus.step_in = 4'd5; bus.mode_in = 2'b01;
    tick();
    total_cnt++;
    if (bus.counter_out !== 8'hFF || bus.ovf_out !== 1'b1)
      $display("FAIL sat_up got cnt=%0h ovf=%b exp cnt=ff ovf=1", bus.counter_out, bus.ovf_out);
    else pass_cnt++;
  endtask

  task automatic test_oneshot();
    load(8'd5, 8'd5);
    bus.en_ctrl_in = 1'b1; bus.up_ctrl_in = 1'b1; bus.step_in = 4'd1; bus.mode_in = 2'b10;
    tick();
    total_cnt++;
    if (bus.counter_out !== 8'd5 || bus.halt_out !== 1'b1 || bus.ovf_out !== 1'b1)
      $display("FAIL oneshot_evt got cnt=%0h halt=%b ovf=%b exp cnt=5 halt=1 ovf=1",
               bus.counter_out, bus.halt_out, bus.ovf_out);
    else pass_cnt++;
    // Mode change and down-counting must not release HALT.
    bus.up_ctrl_in = 1'b0; bus.mode_in = 2'b00;
    tick();
    tick();
    total_cnt++;
    if (bus.counter_out !== 8'd5 || bus.halt_out !== 1'b1 || bus.ovf_out !== 1'b0 || bus.unf_out !== 1'b0)
      $display("FAIL oneshot_hold got cnt=%0h halt=%b ovf=%b unf=%b exp cnt=5 halt=1 ovf=0 unf=0",
               bus.counter_out, bus.halt_out, bus.ovf_out, bus.unf_out);
    else pass_cnt++;
    bus.set_ctrl_in = 1'b1; bus.counter_in = 8'd2;
    tick();
    bus.set_ctrl_in = 1'b0; bus.en_ctrl_in = 1'b0;
    total_cnt++;
    if (bus.counter_out !== 8'd2 || bus.halt_out !== 1'b0)
      $display("FAIL oneshot_reload got cnt=%0h halt=%b exp cnt=2 halt=0", bus.counter_out, bus.halt_out);
    else pass_cnt++;
  endtask

  task automatic test_flag_race();
    idle_inputs();
    bus.flag_clr_in = 1'b1;
    tick();
    total_cnt++;
    if (bus.ovf_sticky_out !== 1'b0 || bus.unf_sticky_out !== 1'b0)
      $display("FAIL flag_clear got %b%b exp 00", bus.ovf_sticky_out, bus.unf_sticky_out);
    else pass_cnt++;
    load(8'h0A, 8'h0A);
    bus.en_ctrl_in = 1'b1; bus.up_ctrl_in = 1'b1; bus.step_in = 4'd1; bus.mode_in = 2'b00;
    bus.flag_clr_in = 1'b1;
    tick();
    total_cnt++;
    if (bus.ovf_sticky_out !== 1'b1 || bus.counter_out !== 8'd0)
      $display("FAIL flag_race got st=%b cnt=%0h exp st=1 cnt=0", bus.ovf_sticky_out, bus.counter_out);
    else pass_cnt++;
    bus.en_ctrl_in = 1'b0;
    tick();
    total_cnt++;
    if (bus.ovf_sticky_out !== 1'b0) $display("FAIL flag_clr_after got %b exp 0", bus.ovf_sticky_out);
    else pass_cnt++;
  endtask

  task automatic test_boundary();
    load(8'h18, 8'h20);
    bus.en_ctrl_in = 1'b1; bus.up_ctrl_in = 1'b1; bus.step_in = 4'd0;
    tick();
    total_cnt++;
    if (bus.counter_out !== 8'h18 || bus.ovf_out !== 1'b0)
      $display("FAIL step_zero got cnt=%0h ovf=%b exp cnt=18 ovf=0", bus.counter_out, bus.ovf_out);
    else pass_cnt++;
    bus.en_ctrl_in = 1'b0; bus.step_in = 4'd7;
    tick();
    total_cnt++;
    if (bus.counter_out !== 8'h18) $display("FAIL en_low got %0h exp 18", bus.counter_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.tc_out !== 1'b0) $display("FAIL tc_low got %b exp 0", bus.tc_out);
    else pass_cnt++;
    bus.limit_in = 8'h18;
    #1;
    total_cnt++;
    if (bus.tc_out !== 1'b1) $display("FAIL tc_high got %b exp 1", bus.tc_out);
    else pass_cnt++;
    bus.limit_in = 8'h10;
    tick();
    total_cnt++;
    if (bus.counter_out !== 8'h18) $display("FAIL limit_no_fix got %0h exp 18", bus.counter_out);
    else pass_cnt++;
    bus.en_ctrl_in = 1'b1; bus.step_in = 4'd1; bus.mode_in = 2'b00;
    tick();
    total_cnt++;
    if (bus.counter_out !== 8'h00 || bus.ovf_out !== 1'b1)
      $display("FAIL limit_lower_ovf got cnt=%0h ovf=%b exp cnt=0 ovf=1", bus.counter_out, bus.ovf_out);
    else pass_cnt++;
    load(8'h10, 8'h20);
    bus.limit_in = 8'h08; bus.en_ctrl_in = 1'b1; bus.up_ctrl_in = 1'b0; bus.step_in = 4'd3;
    tick();
    total_cnt++;
    if (bus.counter_out !== 8'h0D || bus.unf_out !== 1'b0)
      $display("FAIL limit_down got cnt=%0h unf=%b exp cnt=d unf=0", bus.counter_out, bus.unf_out);
    else pass_cnt++;
    idle_inputs();
  endtask

  initial begin
    bus.limit_in = 8'hFF;
    idle_inputs();
    test_reset();
    test_load();
    test_wrap_up();
    test_wrap_down();
    test_sat_down();
    test_oneshot();
    test_flag_race();
    test_boundary();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised up/down counter with load, the successor to the 8-bit loadable up/down counter. Adds configurable width, programmable step and upper limit, and three boundary modes: wrap, saturate and one-shot. Provides overflow/underflow pulses, sticky flags and a terminal-count indication. Used as a general timer/event counter in the control datapath.

Parameters:
WIDTH, 8, counter width in bits (>=2)
STEP_W, 4, width of step_in
RST_VAL, 0, counter value after reset (must be <= 2^WIDTH-1)

Ports:
clk_in  in  1  clock, all state updates on rising edge
rst_in  in  1  synchronous active-high reset
en_ctrl_in  in  1  count enable
set_ctrl_in  in  1  load counter_in (priority over count)
up_ctrl_in  in  1  1 = count up, 0 = count down
counter_in  in  WIDTH  load value
step_in  in  STEP_W  increment/decrement amount
limit_in  in  WIDTH  upper bound (inclusive); lower bound fixed at 0
mode_in  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
flag_clr_in  in  1  clears sticky flags
counter_out  out  WIDTH  registered count
ovf_out  out  1  1-cycle pulse on overflow event
unf_out  out  1  1-cycle pulse on underflow event
ovf_sticky_out  out  1  sticky overflow flag
unf_sticky_out  out  1  sticky underflow flag
tc_out  out  1  combinational: counter_out == limit_in
halt_out  out  1  one-shot mode has stopped (HALT state)

Behaviour:
- Reset (rst_in=1 at edge): counter_out=RST_VAL; ovf_out, unf_out, both sticky flags and halt_out=0; state=RUN. Reset overrides every other input.
- Priority per edge: rst_in > set_ctrl_in > en_ctrl_in. All outputs except tc_out are registered with 1-cycle latency.
- Load: counter_out <= min(counter_in, limit_in); state <= RUN; no ovf/unf pulse. Load works regardless of en_ctrl_in and state.
- Count (en=1, set=0, state=RUN): compute in WIDTH+1 bits.
  - Up: nxt = cnt + step_in; overflow if nxt > limit_in.
  - Down: overflow is not possible; underflow if cnt < step_in.
- Result without an event: cnt <= nxt.
- Overflow by mode: wrap -> 0; saturate -> limit_in; one-shot -> limit_in and state <= HALT.
- Underflow by mode: wrap -> limit_in; saturate -> 0; one-shot -> 0 and state <= HALT.
- Event pulses: ovf_out/unf_out are high for exactly the cycle following the event edge, in every mode including saturate. A saturated counter still asserting the same direction re-pulses every enabled cycle.
- step_in=0: counter holds; no events.
- en_ctrl_in=0: counter holds; pulses are 0.
- FSM has two states: RUN and HALT.
  - RUN -> HALT: on an event in one-shot mode.
  - HALT -> RUN: on set_ctrl_in or rst_in only.
  - In HALT, en_ctrl_in is ignored and counter_out holds. halt_out = (state==HALT).
- Sticky flags: set on their event and held until flag_clr_in. If flag_clr_in and a new event occur on the same edge, the flag is set (event wins).
- limit_in changes mid-count:
  - No immediate correction to counter_out.
  - If cnt > new limit, the next enabled up-step is an overflow.
  - Down-steps proceed normally from cnt.
- mode_in changes take effect on the next edge; a change does not exit HALT.

Decomposition:
- Package counter_pkg holds:
  - mode enum: MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10
  - state enum: ST_RUN, ST_HALT
- One combinational sub-module, counter_step_unit, takes cnt, step, limit, up and mode. It outputs the next value, ovf and unf. The top holds the registers, FSM and sticky flags.

Test Plan:
- Reset/load: rst_in=1 with RST_VAL=0 -> counter_out=0, all flags 0. Load counter_in=0xF0 with limit=0x80 -> counter_out=0x80, no pulse.
- Wrap up: limit=0x0A, step=3, mode=00, cnt=9, en=1, up=1 -> next cnt=0, ovf_out pulse 1 cycle, ovf_sticky_out=1. Following cycle: cnt=3, ovf_out=0.
- Saturate down: limit=0xFF, step=4, cnt=2, up=0, mode=01 -> cnt=0 with unf_out=1. Next enabled cycle: cnt=0, unf_out=1 again.
- One-shot halt: limit=5, step=1, cnt=5, up=1, mode=10 -> cnt=5, halt_out=1, ovf_out pulse. Further enables leave cnt=5. set with counter_in=2 -> cnt=2, halt_out=0.
- Flag race: ovf event and flag_clr_in=1 on the same edge -> ovf_sticky_out=1. Next edge with clr=1 and no event -> 0.
- Boundary: step=0 -> counter holds. en=0 -> counter holds. tc_out=1 when counter_out==limit_in. Lowering limit from 0x20 to 0x10 with cnt=0x18, then up step=1, mode=00 -> cnt=0, ovf pulse.
